vga_multi_digit_display: RTL and testbench

- Parametrised successor to the single-digit VGA seven-segment renderer.
- Draws N_DIGITS seven-segment digits, each with a decimal point, on a 640x480@60 Hz VGA raster.
- Adds programmable foreground and background colour, programmable sync polarity, a tear-free frame-synchronous input latch, and a 2-stage pixel pipeline with aligned syncs.
- Sits between the display-value logic (BCD-to-segment decoders) and the VGA DAC pins.

---
 rtl/vga_multi_digit_display_if.sv | 26 ++
 rtl/vga_multi_digit_display.sv | 188 ++++++++++++++++++
 tb/tb_vga_multi_digit_display.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_multi_digit_display_if.sv
// Signal bundle between the display-value logic, vga_multi_digit_display and the VGA DAC pins.
// N_DIGITS must match the N_DIGITS of the attached vga_multi_digit_display.
interface vga_multi_digit_display_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                  ce;
    logic [7*N_DIGITS-1:0] seg;
    logic [N_DIGITS-1:0]   dp;
    logic [11:0]           fg_color;
    logic [11:0]           bg_color;
    logic                  h_sync;
    logic                  v_sync;
    logic [11:0]           rgb;
    logic                  video_on;
    logic                  frame_start;

    modport master (
        output ce, seg, dp, fg_color, bg_color,
        input  h_sync, v_sync, rgb, video_on, frame_start
    );

    modport slave (
        input  ce, seg, dp, fg_color, bg_color,
        output h_sync, v_sync, rgb, video_on, frame_start
    );
endinterface

// File: rtl/vga_multi_digit_display.sv
// N-digit seven-segment renderer on a VGA raster with frame-synchronous input latch
// and a 2-stage pixel pipeline whose syncs stay aligned with rgb.
module vga_multi_digit_display #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_PULSE     = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_PULSE     = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int          HW          = 6,
    parameter int          HL          = 30,
    parameter int          DIGIT_PITCH = 100,
    parameter int          X_ORIGIN    = 170,
    parameter int          Y_ORIGIN    = 240
) (
    input logic                      clk,
    input logic                      rst,
    vga_multi_digit_display_if.slave bus
);
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_PULSE + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_PULSE + V_BP;
    localparam int unsigned H_START = H_PULSE + H_BP;
    localparam int unsigned V_START = V_PULSE + V_BP;
    localparam int unsigned H_END   = H_START + H_DISPLAY;
    localparam int unsigned V_END   = V_START + V_DISPLAY;

    if (H_TOTAL > 1024) begin : g_h_total_err
        $error("H_TOTAL does not fit the 10-bit horizontal counter");
    end
    if (V_TOTAL > 1024) begin : g_v_total_err
        $error("V_TOTAL does not fit the 10-bit vertical counter");
    end
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_n_digits_err
        $error("N_DIGITS must be in 1..8");
    end

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       latch_en;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (bus.ce) begin
            if (h_cnt_q == 10'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Gated by rst so frame_start reads 0 while reset holds the counters at the origin.
    assign latch_en        = bus.ce && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign bus.frame_start = latch_en && !rst;

    logic [7*N_DIGITS-1:0] seg_sh_q;
    logic [N_DIGITS-1:0]   dp_sh_q;
    logic [11:0]           fg_sh_q;
    logic [11:0]           bg_sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_sh_q <= '0;
            dp_sh_q  <= '0;
            fg_sh_q  <= '0;
            bg_sh_q  <= '0;
        end else if (latch_en) begin
            seg_sh_q <= bus.seg;
            dp_sh_q  <= bus.dp;
            fg_sh_q  <= bus.fg_color;
            bg_sh_q  <= bus.bg_color;
        end
    end

    logic               hs_raw, vs_raw, active;
    logic signed [10:0] x_s, y_s;

    assign hs_raw = (h_cnt_q < 10'(H_PULSE));
    assign vs_raw = (v_cnt_q < 10'(V_PULSE));
    assign active = (h_cnt_q >= 10'(H_START)) && (h_cnt_q < 10'(H_END)) &&
                    (v_cnt_q >= 10'(V_START)) && (v_cnt_q < 10'(V_END));
    assign x_s    = signed'({1'b0, h_cnt_q} - 11'(H_START));
    assign y_s    = signed'({1'b0, v_cnt_q} - 11'(V_START));

    // Stage 1: digit-relative offsets, 12 bits so the leftmost offset of 8 digits cannot wrap.
    logic signed [11:0] dx_d [N_DIGITS];
    logic signed [11:0] dx_q [N_DIGITS];
    logic signed [11:0] dy_d, dy_q;
    logic               act1_q, hs1_q, vs1_q;

    always_comb begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            dx_d[i] = 12'(int'(x_s) - X_ORIGIN - int'(N_DIGITS - 1 - i) * DIGIT_PITCH);
        end
        dy_d = 12'(int'(y_s) - Y_ORIGIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                dx_q[i] <= '0;
            end
            dy_q   <= '0;
            act1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
        end else if (bus.ce) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                dx_q[i] <= dx_d[i];
            end
            dy_q   <= dy_d;
            act1_q <= active;
            hs1_q  <= hs_raw;
            vs1_q  <= vs_raw;
        end
    end

    function automatic logic in_rng(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Stage 2: region hits per digit; hit bit order is {dp,g,f,e,d,c,b,a}.
    logic        lit;
    logic [7:0]  hit;
    int          dxv;
    int          dyv;
    logic [11:0] rgb_d, rgb_q;
    logic        h_sync_d, h_sync_q;
    logic        v_sync_d, v_sync_q;
    logic        video_on_q;

    always_comb begin
        lit = 1'b0;
        hit = '0;
        dxv = 0;
        dyv = int'(dy_q);
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            dxv    = int'(dx_q[i]);
            hit[0] = in_rng(dxv, -HL, HL)           && in_rng(dyv, -2*HL - HW, -2*HL + HW);
            hit[1] = in_rng(dxv, HL - HW, HL + HW)  && in_rng(dyv, -2*HL, 0);
            hit[2] = in_rng(dxv, HL - HW, HL + HW)  && in_rng(dyv, 0, 2*HL);
            hit[3] = in_rng(dxv, -HL, HL)           && in_rng(dyv, 2*HL - HW, 2*HL + HW);
            hit[4] = in_rng(dxv, -HL - HW, -HL + HW) && in_rng(dyv, 0, 2*HL);
            hit[5] = in_rng(dxv, -HL - HW, -HL + HW) && in_rng(dyv, -2*HL, 0);
            hit[6] = in_rng(dxv, -HL, HL)           && in_rng(dyv, -HW, HW);
            hit[7] = in_rng(dxv, HL + 2*HW, HL + 4*HW) && in_rng(dyv, 2*HL - HW, 2*HL + HW);
            lit    = lit | (|(hit & {dp_sh_q[i], seg_sh_q[7*i +: 7]}));
        end
        rgb_d    = !act1_q ? '0 : (lit ? fg_sh_q : bg_sh_q);
        h_sync_d = ~(hs1_q ^ SYNC_POL);
        v_sync_d = ~(vs1_q ^ SYNC_POL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q      <= '0;
            video_on_q <= 1'b0;
            h_sync_q   <= ~SYNC_POL;
            v_sync_q   <= ~SYNC_POL;
        end else if (bus.ce) begin
            rgb_q      <= rgb_d;
            video_on_q <= act1_q;
            h_sync_q   <= h_sync_d;
            v_sync_q   <= v_sync_d;
        end
    end

    assign bus.rgb      = rgb_q;
    assign bus.video_on = video_on_q;
    assign bus.h_sync   = h_sync_q;
    assign bus.v_sync   = v_sync_q;
endmodule

// File: tb/tb_vga_multi_digit_display.sv
// Directed bench for vga_multi_digit_display on a reduced raster (58x37) so whole frames stay short.
module tb_vga_multi_digit_display;
    localparam int HT   = 58;
    localparam int VT   = 37;
    localparam int FT   = HT * VT;
    localparam int HOFF = 14;
    localparam int VOFF = 5;

    localparam logic [27:0] SEG_PAT = {7'h7F, 7'h08, 7'h01, 7'h40};
    localparam logic [3:0]  DP_PAT  = 4'b0100;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    vga_multi_digit_display_if #(.N_DIGITS(4)) bus ();
    vga_multi_digit_display_if #(.N_DIGITS(1)) bus2 ();

    vga_multi_digit_display #(
        .N_DIGITS(4), .H_DISPLAY(40), .H_FP(4), .H_PULSE(8), .H_BP(6),
        .V_DISPLAY(30), .V_FP(2), .V_PULSE(2), .V_BP(3), .SYNC_POL(1'b0),
        .HW(1), .HL(3), .DIGIT_PITCH(10), .X_ORIGIN(8), .Y_ORIGIN(12)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    vga_multi_digit_display #(
        .N_DIGITS(1), .H_DISPLAY(40), .H_FP(4), .H_PULSE(8), .H_BP(6),
        .V_DISPLAY(30), .V_FP(2), .V_PULSE(2), .V_BP(3), .SYNC_POL(1'b1),
        .HW(1), .HL(3), .DIGIT_PITCH(10), .X_ORIGIN(20), .Y_ORIGIN(12)
    ) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        von;
    } vec_t;

    vec_t vecs [15];
    int   errors = 0;
    int   checks = 0;
    int   cyc, cyc2, last_fs;
    int   hs_lo, vs_lo, fs_cnt, hold_err;
    bit   count_en, ce_div;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pos(input int f, input int x, input int y);
        return f * FT + (y + VOFF) * HT + x + HOFF;
    endfunction

    task automatic sample();
        if (count_en) begin
            if (!bus.h_sync) hs_lo++;
            if (!bus.v_sync) vs_lo++;
            if (bus.frame_start) fs_cnt++;
        end
        if (bus.frame_start) begin
            if (last_fs >= 0) chk("fs_period", cyc - last_fs, FT);
            last_fs = cyc;
        end
    endtask

    task automatic step();
        logic [14:0] snap;
        bus.ce = 1'b1;
        @(posedge clk); #1;
        cyc++;
        sample();
        if (ce_div) begin
            snap   = {bus.rgb, bus.h_sync, bus.v_sync, bus.video_on};
            bus.ce = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if ({bus.rgb, bus.h_sync, bus.v_sync, bus.video_on} !== snap) hold_err++;
                sample();
            end
        end
    endtask

    task automatic goto(input int target);
        if (cyc > target) chk("goto_order", cyc, target);
        while (cyc < target) step();
    endtask

    task automatic check_pix(input string nm, input int f, input int x, input int y,
                             input logic [11:0] rgb, input logic von);
        goto(pos(f, x, y) + 2);
        chk({nm, "_rgb"}, bus.rgb, rgb);
        chk({nm, "_von"}, bus.video_on, von);
    endtask

    task automatic run_table(input string pfx);
        for (int k = 0; k < 15; k++) begin
            check_pix($sformatf("%svec%0d", pfx, k), 0, vecs[k].x, vecs[k].y, vecs[k].rgb, vecs[k].von);
        end
    endtask

    task automatic step2();
        @(posedge clk); #1;
        cyc2++;
    endtask

    task automatic goto2(input int target);
        if (cyc2 > target) chk("goto2_order", cyc2, target);
        while (cyc2 < target) step2();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{0,  0,  12'h123, 1'b1};
        vecs[1]  = '{28, 5,  12'hABC, 1'b1};
        vecs[2]  = '{31, 5,  12'h123, 1'b1};
        vecs[3]  = '{25, 6,  12'hABC, 1'b1};
        vecs[4]  = '{8,  9,  12'h123, 1'b1};
        vecs[5]  = '{11, 9,  12'hABC, 1'b1};
        vecs[6]  = '{-3, 12, 12'h000, 1'b0};
        vecs[7]  = '{28, 12, 12'h123, 1'b1};
        vecs[8]  = '{38, 12, 12'hABC, 1'b1};
        vecs[9]  = '{38, 13, 12'h123, 1'b1};
        vecs[10] = '{18, 17, 12'hABC, 1'b1};
        vecs[11] = '{23, 18, 12'hABC, 1'b1};
        vecs[12] = '{33, 18, 12'h123, 1'b1};
        vecs[13] = '{39, 29, 12'h123, 1'b1};
        vecs[14] = '{40, 29, 12'h000, 1'b0};

        rst = 1'b1; rst2 = 1'b1;
        ce_div = 1'b0; count_en = 1'b0; last_fs = -1; cyc = 0; cyc2 = 0;
        hs_lo = 0; vs_lo = 0; fs_cnt = 0; hold_err = 0;
        bus.ce = 1'b1; bus.seg = SEG_PAT; bus.dp = DP_PAT;
        bus.fg_color = 12'hABC; bus.bg_color = 12'h123;
        bus2.ce = 1'b1; bus2.seg = 7'h40; bus2.dp = 1'b0;
        bus2.fg_color = 12'hF0F; bus2.bg_color = 12'h0A0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", bus.h_sync, 1'b1);
        chk("rst_vsync", bus.v_sync, 1'b1);
        chk("rst_rgb", bus.rgb, 12'h000);
        chk("rst_von", bus.video_on, 1'b0);
        chk("rst_fs", bus.frame_start, 1'b0);
        chk("rst2_hsync", bus2.h_sync, 1'b0);
        chk("rst2_vsync", bus2.v_sync, 1'b0);

        rst = 1'b0;
        #1;
        chk("fs_at_release", bus.frame_start, 1'b1);
        last_fs = 0;
        step();
        chk("first_out_rgb", bus.rgb, 12'h000);
        chk("first_fs_low", bus.frame_start, 1'b0);

        run_table("");

        // Frame 1: sync/frame_start census plus a mid-frame input change.
        goto(FT);
        count_en = 1'b1;
        goto(pos(1, 0, 8) + 2);
        bus.seg = '0;
        bus.dp  = '0;
        check_pix("midchg_same_frame_g", 1, 38, 12, 12'hABC, 1'b1);
        check_pix("midchg_same_frame_d", 1, 18, 17, 12'hABC, 1'b1);
        goto(2 * FT);
        count_en = 1'b0;
        chk("hs_low_count", hs_lo, 8 * VT);
        chk("vs_low_count", vs_lo, 2 * HT);
        chk("fs_count", fs_cnt, 1);

        check_pix("midchg_next_frame_g", 2, 38, 12, 12'h123, 1'b1);
        check_pix("pre_rst", 2, 10, 20, 12'h123, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rgb", bus.rgb, 12'h000);
        chk("async_rst_von", bus.video_on, 1'b0);
        chk("async_rst_hsync", bus.h_sync, 1'b1);
        chk("async_rst_vsync", bus.v_sync, 1'b1);

        // Restart with ce asserted one clock in four.
        repeat (2) @(posedge clk);
        bus.seg = SEG_PAT; bus.dp = DP_PAT; bus.ce = 1'b1;
        ce_div = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 0; last_fs = -1;
        #1;
        chk("ce_fs_at_release", bus.frame_start, 1'b1);
        last_fs = 0;
        step();
        chk("ce_out1_rgb", bus.rgb, 12'h000);
        step();
        chk("ce_out2_rgb", bus.rgb, 12'h000);
        run_table("ce_");
        goto(FT);
        hs_lo = 0; vs_lo = 0; fs_cnt = 0;
        count_en = 1'b1;
        goto(2 * FT);
        count_en = 1'b0;
        chk("ce_hs_low_count", hs_lo, 4 * 8 * VT);
        chk("ce_vs_low_count", vs_lo, 4 * 2 * HT);
        chk("ce_fs_count", fs_cnt, 1);
        chk("ce_hold_stable", hold_err, 0);

        // Second instance: active-high syncs, single digit centred at x=20.
        @(posedge clk); #1;
        rst2 = 1'b0; cyc2 = 0;
        #1;
        chk("p1_fs_at_release", bus2.frame_start, 1'b1);
        goto2(2);
        chk("p1_hs_h0", bus2.h_sync, 1'b1);
        chk("p1_vs_v0", bus2.v_sync, 1'b1);
        chk("p1_rgb_h0", bus2.rgb, 12'h000);
        goto2(7 + 2);
        chk("p1_hs_h7", bus2.h_sync, 1'b1);
        goto2(8 + 2);
        chk("p1_hs_h8", bus2.h_sync, 1'b0);
        goto2(HT + 20 + 2);
        chk("p1_vs_v1", bus2.v_sync, 1'b1);
        goto2(2 * HT + 20 + 2);
        chk("p1_vs_v2", bus2.v_sync, 1'b0);
        goto2(pos(0, 20, 12) + 2);
        chk("p1_g_centre_rgb", bus2.rgb, 12'hF0F);
        chk("p1_g_centre_von", bus2.video_on, 1'b1);
        goto2(pos(0, 24, 12) + 2);
        chk("p1_g_right_rgb", bus2.rgb, 12'h0A0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
